// File: rtl/dm_store_buffer.sv
// Store buffer between the core data-memory ports and the data RAM: FIFO of whole-word stores drained over valid/ready.
// Optional load forwarding from pending stores is enabled by defining DM_SB_FORWARD_EN.
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dm_rd_req_i,
    input  logic [AW-1:0] dm_rd_addr_i,
    output logic [DW-1:0] dm_rd_data_o,
    input  logic          dm_wr_req_i,
    input  logic [AW-1:0] dm_wr_addr_i,
    input  logic [DW-1:0] dm_wr_data_i,
    output logic          stall_o,
    output logic          mem_rd_req_o,
    output logic [AW-1:0] mem_rd_addr_o,
    input  logic [DW-1:0] mem_rd_data_i,
    output logic          mem_wr_valid_o,
    input  logic          mem_wr_ready_i,
    output logic [AW-1:0] mem_wr_addr_o,
    output logic [DW-1:0] mem_wr_data_o,
    output logic          sb_empty_o
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic full;
    logic push;
    logic pop;

    assign full           = (count == FULL_CNT);
    assign mem_wr_valid_o = (count != '0);
    assign sb_empty_o     = (count == '0);
    assign mem_wr_addr_o  = addr_q[rd_ptr];
    assign mem_wr_data_o  = data_q[rd_ptr];
    assign mem_rd_req_o   = dm_rd_req_i;
    assign mem_rd_addr_o  = dm_rd_addr_i;

    // A stalled store is held by the core and re-presented, so it must not be queued now.
    assign push = dm_wr_req_i && !stall_o;
    assign pop  = mem_wr_valid_o && mem_wr_ready_i;

`ifdef DM_SB_FORWARD_EN
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    assign stall_o = dm_wr_req_i && full;

    // Walk backward from the newest entry so the latest matching store wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = wr_ptr - PW'(i + 1);
            if (!fwd_hit && ((PW+1)'(i) < count) && (addr_q[fwd_idx] == dm_rd_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        dm_rd_data_o = mem_rd_data_i;
        if (dm_rd_req_i) begin
            if (dm_wr_req_i && !stall_o && (dm_wr_addr_i == dm_rd_addr_i)) begin
                dm_rd_data_o = dm_wr_data_i;
            end else if (fwd_hit) begin
                dm_rd_data_o = fwd_data;
            end
        end
    end
`else
    // Without forwarding, a load waits until no store is pending or arriving.
    assign stall_o      = (dm_wr_req_i && full) ||
                          (dm_rd_req_i && ((count != '0) || dm_wr_req_i));
    assign dm_rd_data_o = mem_rd_data_i;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= dm_wr_addr_i;
            data_q[wr_ptr] <= dm_wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: directed stores queue expected RAM writes, a monitor checks each drained write.
// Forwarding checks run when DM_SB_FORWARD_EN is defined, stall-based coherence checks otherwise.
module tb_dm_store_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_rd_req_i;
    logic [31:0] dm_rd_addr_i;
    logic [31:0] dm_rd_data_o;
    logic        dm_wr_req_i;
    logic [31:0] dm_wr_addr_i;
    logic [31:0] dm_wr_data_i;
    logic        stall_o;
    logic        mem_rd_req_o;
    logic [31:0] mem_rd_addr_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_wr_valid_o;
    logic        mem_wr_ready_i;
    logic [31:0] mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;
    logic        sb_empty_o;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  pops   = 0;
    int  pops0;

    dm_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .dm_rd_req_i    (dm_rd_req_i),
        .dm_rd_addr_i   (dm_rd_addr_i),
        .dm_rd_data_o   (dm_rd_data_o),
        .dm_wr_req_i    (dm_wr_req_i),
        .dm_wr_addr_i   (dm_wr_addr_i),
        .dm_wr_data_i   (dm_wr_data_i),
        .stall_o        (stall_o),
        .mem_rd_req_o   (mem_rd_req_o),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_wr_valid_o (mem_wr_valid_o),
        .mem_wr_ready_i (mem_wr_ready_i),
        .mem_wr_addr_o  (mem_wr_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .sb_empty_o     (sb_empty_o)
    );

    always #5 clk = ~clk;

    // RAM read data is a known function of the load address.
    assign mem_rd_data_i = 32'hC0DE_0000 | dm_rd_addr_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst && mem_wr_valid_o && mem_wr_ready_i) begin
            pops++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         mem_wr_addr_o, mem_wr_data_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_wr_addr_o, e.a);
                chk("wr_data", mem_wr_data_o, e.d);
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1 with the store request dropped.
    task automatic issue_store(input logic [31:0] a, input logic [31:0] d, input logic acc);
        dm_wr_req_i  = 1'b1;
        dm_wr_addr_i = a;
        dm_wr_data_i = d;
        @(negedge clk);
        chk("store_stall", {31'b0, stall_o}, {31'b0, !acc});
        if (acc) exp_q.push_back('{a: a, d: d});
        @(posedge clk);
        #1;
        dm_wr_req_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        mem_wr_ready_i = 1'b1;
        @(negedge clk);
        while (!sb_empty_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", {31'b0, sb_empty_o}, 32'd1);
        chk("queue_left", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
        mem_wr_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        dm_rd_req_i    = 1'b0;
        dm_rd_addr_i   = '0;
        dm_wr_req_i    = 1'b1;
        dm_wr_addr_i   = 32'h0;
        dm_wr_data_i   = 32'h0;
        mem_wr_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", {31'b0, mem_wr_valid_o}, 32'd0);
        chk("rst_empty", {31'b0, sb_empty_o}, 32'd1);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        dm_wr_req_i = 1'b0;
        rst         = 1'b0;

        // Load pass-through with an empty buffer.
        dm_rd_req_i  = 1'b1;
        dm_rd_addr_i = 32'h100;
        @(negedge clk);
        chk("rd_req_mirror", {31'b0, mem_rd_req_o}, 32'd1);
        chk("rd_addr_mirror", mem_rd_addr_o, 32'h100);
        chk("rd_data_empty", dm_rd_data_o, 32'hC0DE_0100);
        chk("rd_stall_empty", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        dm_rd_req_i = 1'b0;

        // Fill to full, fifth store stalls, then drain one per cycle.
        for (int i = 0; i < 4; i++) issue_store(32'h10 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1);
        issue_store(32'h20, 32'h2000, 1'b0);
        @(negedge clk);
        chk("full_valid", {31'b0, mem_wr_valid_o}, 32'd1);
        chk("full_head", mem_wr_addr_o, 32'h10);
        @(posedge clk);
        #1;
        mem_wr_ready_i = 1'b1;
        pops0 = pops;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("fill_drain_pops", pops - pops0, 32'd4);
        chk("fill_drain_empty", {31'b0, sb_empty_o}, 32'd1);
        @(posedge clk);
        #1;
        mem_wr_ready_i = 1'b0;

        // Concurrent push/pop with two entries resident.
        issue_store(32'h50, 32'h5000, 1'b1);
        issue_store(32'h54, 32'h5001, 1'b1);
        mem_wr_ready_i = 1'b1;
        pops0 = pops;
        for (int i = 0; i < 6; i++) issue_store(32'h58 + 32'(4 * i), 32'h5002 + 32'(i), 1'b1);
        mem_wr_ready_i = 1'b0;
        @(negedge clk);
        chk("concurrent_pops", pops - pops0, 32'd6);
        chk("concurrent_left", exp_q.size(), 32'd2);
        chk("concurrent_valid", {31'b0, mem_wr_valid_o}, 32'd1);
        @(posedge clk);
        #1;
        wait_empty();

        // Wrap: ten back-to-back rounds, repeated addresses must not coalesce.
        mem_wr_ready_i = 1'b1;
        for (int r = 0; r < 10; r++) issue_store(32'h40 + 32'(4 * (r % 2)), 32'h4000 + 32'(r), 1'b1);
        wait_empty();

        // Reset mid-traffic with three pending stores.
        for (int i = 0; i < 3; i++) issue_store(32'h60 + 32'(4 * i), 32'h6000 + 32'(i), 1'b1);
        @(negedge clk);
        chk("pre_rst_empty", {31'b0, sb_empty_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("async_rst_valid", {31'b0, mem_wr_valid_o}, 32'd0);
        chk("async_rst_empty", {31'b0, sb_empty_o}, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        mem_wr_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_empty", {31'b0, sb_empty_o}, 32'd1);
        @(posedge clk);
        #1;
        mem_wr_ready_i = 1'b0;

`ifdef DM_SB_FORWARD_EN
        issue_store(32'h20, 32'hAAAA, 1'b1);
        issue_store(32'h20, 32'hBBBB, 1'b1);
        dm_rd_req_i  = 1'b1;
        dm_rd_addr_i = 32'h20;
        @(negedge clk);
        chk("fwd_newest", dm_rd_data_o, 32'hBBBB);
        chk("fwd_no_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        dm_rd_addr_i = 32'h24;
        issue_store(32'h24, 32'hCCCC, 1'b1);
        chk("fwd_same_cycle_fallthrough", dm_rd_data_o, 32'hCCCC);
        dm_rd_addr_i = 32'h28;
        @(negedge clk);
        chk("fwd_miss", dm_rd_data_o, 32'hC0DE_0028);
        @(posedge clk);
        #1;
        dm_rd_req_i = 1'b0;
        wait_empty();
`else
        issue_store(32'h30, 32'h3333, 1'b1);
        dm_rd_req_i  = 1'b1;
        dm_rd_addr_i = 32'h30;
        repeat (3) begin
            @(negedge clk);
            chk("nofwd_stall_pending", {31'b0, stall_o}, 32'd1);
            @(posedge clk);
            #1;
        end
        mem_wr_ready_i = 1'b1;
        @(negedge clk);
        chk("nofwd_stall_pop_cycle", {31'b0, stall_o}, 32'd1);
        @(posedge clk);
        #1;
        mem_wr_ready_i = 1'b0;
        @(negedge clk);
        chk("nofwd_stall_released", {31'b0, stall_o}, 32'd0);
        chk("nofwd_rd_data", dm_rd_data_o, 32'hC0DE_0030);
        chk("nofwd_empty", {31'b0, sb_empty_o}, 32'd1);
        chk("nofwd_queue", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
        dm_rd_req_i = 1'b0;
`endif

        wait_empty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
